load_store_buffer: RTL and testbench
====================================

# load_store_buffer

In-order load/store buffer sitting between dispatch, the reorder buffer (ROB) and the memory controller. It holds dispatched memory ops and resolves their operands by snooping the EX result bus and its own load results. Loads execute at the head and return data to the ROB. Stores execute only after the ROB signals commit for their nick. It is the consumer of the ROB store-commit interface and the producer of the ROB load-result interface.

## Interface
- DEPTH, 16: entry count, power of two.
- NICK_W, 5: ROB tag width; nick 0 = "no tag / value ready".
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low = all state frozen, outputs held.
- clr  in  1  mispredict flush from ROB.
- oFull  out  1  combinational, count == DEPTH.
- iDP_en  in  1  dispatch valid.
- iDP_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- iDP_nick  in  NICK_W  ROB tag of this op.
- iDP_v1/iDP_q1  in  32/NICK_W  base operand value / tag.
- iDP_v2/iDP_q2  in  32/NICK_W  store data value / tag.
- iDP_imm  in  32  sign-extended offset.
- iEX_en, iEX_nick, iEX_dt  in  1/NICK_W/32  EX broadcast.
- iROB_store_en, iROB_commit_nick  in  1/NICK_W  store commit.
- oMEM_req  out  1  memory request, held until done.
- oMEM_we  out  1  1 = store.
- oMEM_addr  out  32  byte address.
- oMEM_size  out  2  0 byte, 1 half, 2 word.
- oMEM_wdata  out  32  store data, low bytes used.
- iMEM_done  in  1  one-cycle completion pulse.
- iMEM_rdata  in  32  load data, valid with iMEM_done.
- oROB_en, oROB_nick, oROB_dt  out  1/NICK_W/32  load result, also broadcast to ROB.

## Operation
- Circular FIFO: head, tail pointers (log2 DEPTH bits, natural wrap), count (log2 DEPTH + 1 bits).
- Per-entry state: op, nick, v1, q1, v2, q2, imm, committed.
- Dispatch: on iDP_en and !oFull, write at tail; tail++, count++. iDP_en while oFull is ignored.
- Snoop: every valid entry with qX == bus nick (nonzero) takes vX = bus data, qX = 0. Buses snooped are iEX and the own oROB output. This also applies to the entry being dispatched in the same cycle.
- Commit: iROB_store_en sets committed on the valid store entry whose nick matches.
- State machine:
  - IDLE: if the head is valid and q1 == 0, it may issue.
    - Load: issue immediately.
    - Store: issue only when q2 == 0 and committed is set.
  - To issue, register oMEM_req = 1 with we, addr = v1 + imm (32-bit wrap), size, wdata = v2, then go to WAIT.
  - WAIT: hold all oMEM_* stable.
    - On iMEM_done: drop oMEM_req, pop head (head++, count--) and go to IDLE.
    - If the op is a load, also register oROB_en = 1, nick and data. LB/LH sign-extend rdata[7:0]/[15:0]; LBU/LHU zero-extend; LW passes through.
- Flush on clr:
  - Discard all entries whose committed flag is clear. Committed stores are always the oldest contiguous run, so tail = head + committed count.
  - A load in WAIT completes its memory handshake, then returns to IDLE with no oROB_en (squash flag). A store in WAIT continues normally.
  - Dispatch in the clr cycle is ignored.
- Pop, dispatch and commit in the same cycle are all honoured; count nets ±1/0.

## Timing
- Reset values: oMEM_req/we/addr/size/wdata = 0, oROB_en/nick/dt = 0, head = tail = count = 0, state IDLE, all committed = 0. oFull = 0.
- oROB_en is a one-cycle pulse. Snoop takes effect on the cycle after the bus pulse; same-cycle dispatch capture is combinational.
- Load with ready operand at the head in cycle N: oMEM_req high at N+1. With done in cycle M: oROB_en at M+1, and the next head may issue at M+1, so oMEM_req goes high again at M+2.
- Store: commit at cycle N with operands ready gives oMEM_req at N+1 at the earliest, if it is the head.
- rdy low: no state change, and iMEM_done/iEX/iROB pulses arriving in that cycle are ignored. The memory side must not pulse done while rdy is low.
- rst overrides clr and rdy.

## Test plan
- LW base=0x100 imm=4 ready, rdata=0xDEADBEEF at done -> oMEM_addr=0x104, size 2, we 0; oROB_dt=0xDEADBEEF one cycle after done.
- LB rdata=0x00000080 -> oROB_dt=0xFFFFFF80. LBU with the same data -> 0x00000080. LHU 0x0000F00D -> 0x0000F00D.
- SW nick 3, q2=7; EX broadcasts nick 7 data 0x55; ROB commits nick 3 -> exactly one oMEM_req, we 1, wdata 0x55. No request before commit. No oROB_en.
- Fill 16 entries -> oFull=1 and the 17th dispatch is dropped. After pops and refills across index 15->0, ordering is preserved.
- Committed SW at head, two loads behind, clr -> count=1; store completes, no loads issued.
- clr during load WAIT -> handshake completes with no oROB_en. LW nick 2 followed by LW with q1=2 -> the second issues using the first's data.

Source files
------------

// File: rtl/load_store_buffer_if.sv
// Bundle of dispatch, EX snoop, ROB commit/result and memory signals around the load/store buffer.
// The buffer itself uses the master view; the surrounding pipeline drives the slave view.
interface load_store_buffer_if #(
  parameter int unsigned NICK_W = 5
);
  logic              full;

  logic              dp_en;
  logic [2:0]        dp_op;
  logic [NICK_W-1:0] dp_nick;
  logic [31:0]       dp_v1;
  logic [NICK_W-1:0] dp_q1;
  logic [31:0]       dp_v2;
  logic [NICK_W-1:0] dp_q2;
  logic [31:0]       dp_imm;

  logic              ex_en;
  logic [NICK_W-1:0] ex_nick;
  logic [31:0]       ex_dt;

  logic              rob_store_en;
  logic [NICK_W-1:0] rob_commit_nick;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [1:0]        mem_size;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic              rob_en;
  logic [NICK_W-1:0] rob_nick;
  logic [31:0]       rob_dt;

  modport master (
    output full, mem_req, mem_we, mem_addr, mem_size, mem_wdata, rob_en, rob_nick, rob_dt,
    input  dp_en, dp_op, dp_nick, dp_v1, dp_q1, dp_v2, dp_q2, dp_imm,
    input  ex_en, ex_nick, ex_dt, rob_store_en, rob_commit_nick, mem_done, mem_rdata
  );

  modport slave (
    input  full, mem_req, mem_we, mem_addr, mem_size, mem_wdata, rob_en, rob_nick, rob_dt,
    output dp_en, dp_op, dp_nick, dp_v1, dp_q1, dp_v2, dp_q2, dp_imm,
    output ex_en, ex_nick, ex_dt, rob_store_en, rob_commit_nick, mem_done, mem_rdata
  );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: holds dispatched memory ops, resolves operands by snooping,
// issues the head op to memory and returns load results to the ROB.
module load_store_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NICK_W = 5
) (
  input logic                clk,
  input logic                rst,
  input logic                rdy,
  input logic                clr,
  load_store_buffer_if.master bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic [2:0]        op_q        [DEPTH];
  logic [2:0]        op_d        [DEPTH];
  logic [NICK_W-1:0] nick_q      [DEPTH];
  logic [NICK_W-1:0] nick_d      [DEPTH];
  logic [31:0]       v1_q        [DEPTH];
  logic [31:0]       v1_d        [DEPTH];
  logic [NICK_W-1:0] q1_q        [DEPTH];
  logic [NICK_W-1:0] q1_d        [DEPTH];
  logic [31:0]       v2_q        [DEPTH];
  logic [31:0]       v2_d        [DEPTH];
  logic [NICK_W-1:0] q2_q        [DEPTH];
  logic [NICK_W-1:0] q2_d        [DEPTH];
  logic [31:0]       imm_q       [DEPTH];
  logic [31:0]       imm_d       [DEPTH];
  logic [DEPTH-1:0]  committed_q, committed_d;

  logic [IdxW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rob_en_q, rob_en_d;
  logic [NICK_W-1:0] rob_nick_q, rob_nick_d;
  logic [31:0]       rob_dt_q, rob_dt_d;
  // Set when a flush hits an in-flight load: finish the handshake but drop the result.
  logic              squash_q, squash_d;

  logic [DEPTH-1:0] valid;
  logic [CntW-1:0]  ccount;
  logic             full;
  logic             accept;
  logic             pop;
  logic             issue;

  logic [2:0]        head_op;
  logic [NICK_W-1:0] head_nick;
  logic              head_store;
  logic              head_load;
  logic              head_commit;

  function automatic logic is_store(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: return 2'd0;
      3'd1, 3'd4, 3'd6: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] rdata);
    case (op)
      3'd0:    return {{24{rdata[7]}}, rdata[7:0]};
      3'd1:    return {{16{rdata[15]}}, rdata[15:0]};
      3'd3:    return {24'd0, rdata[7:0]};
      3'd4:    return {16'd0, rdata[15:0]};
      default: return rdata;
    endcase
  endfunction

  // Returns {tag, value} after checking the EX bus and our own load-result bus.
  function automatic logic [NICK_W+31:0] snoop(
    input logic [NICK_W-1:0] q,
    input logic [31:0]       v,
    input logic              ex_en,
    input logic [NICK_W-1:0] ex_nick,
    input logic [31:0]       ex_dt,
    input logic              rb_en,
    input logic [NICK_W-1:0] rb_nick,
    input logic [31:0]       rb_dt
  );
    if (q != '0 && ex_en && q == ex_nick) return {{NICK_W{1'b0}}, ex_dt};
    if (q != '0 && rb_en && q == rb_nick) return {{NICK_W{1'b0}}, rb_dt};
    return {q, v};
  endfunction

  assign full        = count_q == CntW'(DEPTH);
  assign head_op     = op_q[head_q];
  assign head_nick   = nick_q[head_q];
  assign head_store  = is_store(head_op);
  assign head_load   = !head_store;
  assign head_commit = committed_q[head_q] ||
                       (!clr && bus.rob_store_en && bus.rob_commit_nick == head_nick);

  always_comb begin
    valid  = '0;
    ccount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, IdxW'(i) - head_q} < count_q;
      ccount   = ccount + CntW'(valid[i] & committed_q[i]);
    end
  end

  // Loads issue as soon as the base is known; stores additionally wait for data and commit.
  always_comb begin
    issue = 1'b0;
    if (count_q != '0 && q1_q[head_q] == '0) begin
      if (head_store) issue = q2_q[head_q] == '0 && head_commit;
      else            issue = !clr;
    end
  end

  always_comb begin
    op_d        = op_q;
    nick_d      = nick_q;
    v1_d        = v1_q;
    q1_d        = q1_q;
    v2_d        = v2_q;
    q2_d        = q2_q;
    imm_d       = imm_q;
    committed_d = committed_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    rob_en_d    = 1'b0;
    rob_nick_d  = rob_nick_q;
    rob_dt_d    = rob_dt_q;
    squash_d    = squash_q;
    pop         = 1'b0;
    accept      = bus.dp_en && !full && !clr;

    for (int i = 0; i < DEPTH; i++) begin
      {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i], bus.ex_en, bus.ex_nick, bus.ex_dt,
                                 rob_en_q, rob_nick_q, rob_dt_q);
      {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i], bus.ex_en, bus.ex_nick, bus.ex_dt,
                                 rob_en_q, rob_nick_q, rob_dt_q);
      if (bus.rob_store_en && valid[i] && is_store(op_q[i]) &&
          nick_q[i] == bus.rob_commit_nick) begin
        committed_d[i] = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (issue) begin
          mem_req_d   = 1'b1;
          mem_we_d    = head_store;
          mem_addr_d  = v1_q[head_q] + imm_q[head_q];
          mem_size_d  = op_size(head_op);
          mem_wdata_d = v2_q[head_q];
          state_d     = StWait;
        end
      end
      StWait: begin
        if (bus.mem_done) begin
          mem_req_d = 1'b0;
          squash_d  = 1'b0;
          state_d   = StIdle;
          // A squashed load's entry is already gone, so nothing is popped for it.
          if (!squash_q && !(clr && head_load)) begin
            pop = 1'b1;
            if (head_load) begin
              rob_en_d   = 1'b1;
              rob_nick_d = head_nick;
              rob_dt_d   = load_ext(head_op, bus.mem_rdata);
            end
          end
        end else if (clr && head_load) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      // Committed stores are the oldest contiguous run, so they are all that survive.
      head_d  = head_q + IdxW'(pop);
      count_d = ccount - CntW'(pop);
      tail_d  = head_q + ccount[IdxW-1:0];
    end else begin
      head_d  = head_q + IdxW'(pop);
      tail_d  = tail_q + IdxW'(accept);
      count_d = count_q + CntW'(accept) - CntW'(pop);
      if (accept) begin
        op_d[tail_q]        = bus.dp_op;
        nick_d[tail_q]      = bus.dp_nick;
        imm_d[tail_q]       = bus.dp_imm;
        committed_d[tail_q] = 1'b0;
        {q1_d[tail_q], v1_d[tail_q]} = snoop(bus.dp_q1, bus.dp_v1, bus.ex_en, bus.ex_nick,
                                             bus.ex_dt, rob_en_q, rob_nick_q, rob_dt_q);
        {q2_d[tail_q], v2_d[tail_q]} = snoop(bus.dp_q2, bus.dp_v2, bus.ex_en, bus.ex_nick,
                                             bus.ex_dt, rob_en_q, rob_nick_q, rob_dt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_d_reset: begin
        op_q   <= '{default: '0};
        nick_q <= '{default: '0};
        v1_q   <= '{default: '0};
        q1_q   <= '{default: '0};
        v2_q   <= '{default: '0};
        q2_q   <= '{default: '0};
        imm_q  <= '{default: '0};
      end
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      rob_en_q    <= 1'b0;
      rob_nick_q  <= '0;
      rob_dt_q    <= '0;
      squash_q    <= 1'b0;
    end else if (rdy) begin
      op_q        <= op_d;
      nick_q      <= nick_d;
      v1_q        <= v1_d;
      q1_q        <= q1_d;
      v2_q        <= v2_d;
      q2_q        <= q2_d;
      imm_q       <= imm_d;
      committed_q <= committed_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      rob_en_q    <= rob_en_d;
      rob_nick_q  <= rob_nick_d;
      rob_dt_q    <= rob_dt_d;
      squash_q    <= squash_d;
    end
  end

  assign bus.full      = full;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rob_en    = rob_en_q;
  assign bus.rob_nick  = rob_nick_q;
  assign bus.rob_dt    = rob_dt_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: load extension, store commit gating, full/wrap ordering,
// flush behaviour and operand forwarding through the load-result bus.
module tb_load_store_buffer;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_buffer_if #(.NICK_W(5)) bus ();

  load_store_buffer #(
    .DEPTH (16),
    .NICK_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .clr(clr),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [4:0] nick, input logic [31:0] v1,
                          input logic [4:0] q1, input logic [31:0] v2, input logic [4:0] q2,
                          input logic [31:0] imm);
    bus.dp_en   = 1'b1;
    bus.dp_op   = op;
    bus.dp_nick = nick;
    bus.dp_v1   = v1;
    bus.dp_q1   = q1;
    bus.dp_v2   = v2;
    bus.dp_q2   = q2;
    bus.dp_imm  = imm;
    tick();
    bus.dp_en   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.mem_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
  endtask

  // Waits for a load request, checks it, completes it and checks the ROB result.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [1:0] exp_size,
                       input logic [31:0] rdata, input logic [31:0] exp_dt);
    wait_req(tag);
    chk({tag, "_addr"}, bus.mem_addr, exp_addr);
    chk({tag, "_size"}, 32'(bus.mem_size), 32'(exp_size));
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_done  = 1'b0;
    chk({tag, "_rob_en"}, 32'(bus.rob_en), 32'd1);
    chk({tag, "_rob_dt"}, bus.rob_dt, exp_dt);
  endtask

  task automatic watch_no_req(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= bus.mem_req;
      tick();
    end
    seen |= bus.mem_req;
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    clr = 1'b0;
    bus.dp_en = 1'b0; bus.dp_op = '0; bus.dp_nick = '0; bus.dp_v1 = '0; bus.dp_q1 = '0;
    bus.dp_v2 = '0; bus.dp_q2 = '0; bus.dp_imm = '0;
    bus.ex_en = 1'b0; bus.ex_nick = '0; bus.ex_dt = '0;
    bus.rob_store_en = 1'b0; bus.rob_commit_nick = '0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_rob_en", 32'(bus.rob_en), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_rob_dt", bus.rob_dt, 32'd0);

    // LW: request one cycle after it sits at the head, result one cycle after done.
    dispatch(3'd2, 5'd1, 32'h100, 5'd0, 32'd0, 5'd0, 32'd4);
    chk("lw_early_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("lw_req_n1", 32'(bus.mem_req), 32'd1);
    serve("lw", 32'h104, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("lw_rob_nick", 32'(bus.rob_nick), 32'd1);
    tick();
    chk("lw_rob_pulse", 32'(bus.rob_en), 32'd0);

    dispatch(3'd0, 5'd1, 32'h10, 5'd0, 32'd0, 5'd0, 32'd1);
    serve("lb", 32'h11, 2'd0, 32'h00000080, 32'hFFFFFF80);
    dispatch(3'd3, 5'd1, 32'h10, 5'd0, 32'd0, 5'd0, 32'd1);
    serve("lbu", 32'h11, 2'd0, 32'h00000080, 32'h00000080);
    dispatch(3'd4, 5'd1, 32'h20, 5'd0, 32'd0, 5'd0, 32'd2);
    serve("lhu", 32'h22, 2'd1, 32'h0000F00D, 32'h0000F00D);
    dispatch(3'd1, 5'd1, 32'h20, 5'd0, 32'd0, 5'd0, 32'd2);
    serve("lh", 32'h22, 2'd1, 32'h00008001, 32'hFFFF8001);
    tick();

    // SW nick 3 waiting on data tag 7 and on commit.
    dispatch(3'd7, 5'd3, 32'h200, 5'd0, 32'd0, 5'd7, 32'd0);
    watch_no_req("sw_wait_data", 3);
    bus.ex_en = 1'b1; bus.ex_nick = 5'd7; bus.ex_dt = 32'h55;
    tick();
    bus.ex_en = 1'b0;
    watch_no_req("sw_wait_commit", 3);
    bus.rob_store_en = 1'b1; bus.rob_commit_nick = 5'd3;
    tick();
    bus.rob_store_en = 1'b0;
    chk("sw_req", 32'(bus.mem_req), 32'd1);
    chk("sw_we", 32'(bus.mem_we), 32'd1);
    chk("sw_addr", bus.mem_addr, 32'h200);
    chk("sw_wdata", bus.mem_wdata, 32'h55);
    chk("sw_size", 32'(bus.mem_size), 32'd2);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    chk("sw_no_rob", 32'(bus.rob_en), 32'd0);
    chk("sw_req_drop", 32'(bus.mem_req), 32'd0);
    watch_no_req("sw_single_req", 4);

    // Fill with loads blocked on tag 31; the 17th dispatch must be dropped.
    for (int k = 0; k < 15; k++) dispatch(3'd2, 5'd8, 32'd0, 5'd31, 32'd0, 5'd0, 32'(4 * k));
    chk("fill15_full", 32'(bus.full), 32'd0);
    dispatch(3'd2, 5'd8, 32'd0, 5'd31, 32'd0, 5'd0, 32'd60);
    chk("fill16_full", 32'(bus.full), 32'd1);
    dispatch(3'd2, 5'd8, 32'd0, 5'd31, 32'd0, 5'd0, 32'h400);
    chk("drop17_count", 32'(dut.count_q), 32'd16);
    bus.ex_en = 1'b1; bus.ex_nick = 5'd31; bus.ex_dt = 32'h1000;
    tick();
    bus.ex_en = 1'b0;
    for (int k = 0; k < 4; k++) serve("wrap_a", 32'h1000 + 32'(4 * k), 2'd2, 32'(k), 32'(k));
    for (int k = 16; k < 20; k++) dispatch(3'd2, 5'd8, 32'h2000, 5'd0, 32'd0, 5'd0, 32'(4 * k));
    for (int k = 4; k < 16; k++) serve("wrap_b", 32'h1000 + 32'(4 * k), 2'd2, 32'(k), 32'(k));
    for (int k = 16; k < 20; k++) serve("wrap_c", 32'h2000 + 32'(4 * k), 2'd2, 32'(k), 32'(k));
    tick();
    chk("wrap_empty", 32'(dut.count_q), 32'd0);

    // Committed SW at head, two loads behind it, then flush.
    dispatch(3'd7, 5'd5, 32'h300, 5'd0, 32'hAB, 5'd0, 32'd0);
    dispatch(3'd2, 5'd6, 32'h400, 5'd0, 32'd0, 5'd0, 32'd0);
    dispatch(3'd2, 5'd7, 32'h404, 5'd0, 32'd0, 5'd0, 32'd0);
    chk("fl_no_req", 32'(bus.mem_req), 32'd0);
    bus.rob_store_en = 1'b1; bus.rob_commit_nick = 5'd5;
    tick();
    bus.rob_store_en = 1'b0;
    chk("fl_sw_req", 32'(bus.mem_req), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("fl_count", 32'(dut.count_q), 32'd1);
    chk("fl_sw_hold", bus.mem_addr, 32'h300);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    chk("fl_sw_no_rob", 32'(bus.rob_en), 32'd0);
    watch_no_req("fl_loads_gone", 5);

    // Flush while a load waits on memory: handshake finishes, result suppressed.
    dispatch(3'd2, 5'd9, 32'h500, 5'd0, 32'd0, 5'd0, 32'd0);
    wait_req("sq");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sq_count", 32'(dut.count_q), 32'd0);
    chk("sq_req_hold", 32'(bus.mem_req), 32'd1);
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h1234;
    tick();
    bus.mem_done = 1'b0;
    chk("sq_no_rob", 32'(bus.rob_en), 32'd0);
    chk("sq_req_drop", 32'(bus.mem_req), 32'd0);
    watch_no_req("sq_idle", 3);

    // Second load's base comes from the first load's result.
    dispatch(3'd2, 5'd2, 32'h600, 5'd0, 32'd0, 5'd0, 32'd0);
    dispatch(3'd2, 5'd4, 32'd0, 5'd2, 32'd0, 5'd0, 32'd8);
    serve("dep1", 32'h600, 2'd2, 32'h700, 32'h700);
    wait_req("dep2_pre");
    rdy = 1'b0;
    tick();
    tick();
    chk("rdy_hold_req", 32'(bus.mem_req), 32'd1);
    chk("rdy_hold_addr", bus.mem_addr, 32'h708);
    rdy = 1'b1;
    serve("dep2", 32'h708, 2'd2, 32'h99, 32'h99);
    chk("dep2_nick", 32'(bus.rob_nick), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
